// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the external requester and the data memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_rvalid;

  logic             ext_req;
  logic             ext_we;
  logic [WIDTH-1:0] ext_addr;
  logic [WIDTH-1:0] ext_wdata;
  logic             ext_lock;
  logic             ext_gnt;
  logic [WIDTH-1:0] ext_rdata;
  logic             ext_rvalid;

  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU data port and an external requester.
// Define ARB_STARVE_GUARD_EN to add the CPU wait counter that forces a grant after MAX_WAIT stalls.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT,
    OWN_EXT_LOCKED
  } owner_t;

  owner_t           owner;
  logic             rr;
  logic             force_cpu;
  logic             cpu_win;
  logic             ext_win;
  logic             cpu_gnt;
  logic             ext_gnt;
  logic [WIDTH-1:0] cpu_rdata;
  logic [WIDTH-1:0] ext_rdata;
  logic             cpu_rvalid;
  logic             ext_rvalid;

`ifdef ARB_STARVE_GUARD_EN
  localparam int            WW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [WW-1:0] wcnt;

  assign force_cpu = bus.cpu_req && (wcnt == WMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
    end else if (!bus.cpu_req || cpu_gnt) begin
      wcnt <= '0;
    end else if (wcnt != WMAX) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  // The starved CPU overrides everything, including an external lock.
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (force_cpu) begin
      cpu_win = 1'b1;
    end else if (owner == OWN_EXT_LOCKED) begin
      ext_win = bus.ext_req;
    end else if (bus.cpu_req && bus.ext_req) begin
      cpu_win = ~rr;
      ext_win = rr;
    end else begin
      cpu_win = bus.cpu_req;
      ext_win = bus.ext_req;
    end
  end

  // Grants are masked during reset so an in-flight write is never committed.
  assign cpu_gnt = cpu_win & ~reset;
  assign ext_gnt = ext_win & ~reset;

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt & ~reset;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.ext_rdata  = ext_rdata;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.ext_rvalid = ext_rvalid;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (ext_gnt) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  // rr only moves on unlocked grants and always points at the loser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_NONE;
      rr    <= 1'b0;
    end else if (force_cpu) begin
      owner <= OWN_NONE;
      rr    <= 1'b1;
    end else if (owner == OWN_EXT_LOCKED) begin
      if (!(bus.ext_req && bus.ext_lock)) begin
        owner <= OWN_NONE;
      end
    end else if (ext_gnt) begin
      owner <= bus.ext_lock ? OWN_EXT_LOCKED : OWN_EXT;
      rr    <= 1'b0;
    end else if (cpu_gnt) begin
      owner <= OWN_CPU;
      rr    <= 1'b1;
    end else begin
      owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~bus.cpu_we;
      ext_rvalid <= ext_gnt & ~bus.ext_we;
      if (cpu_gnt && !bus.cpu_we) begin
        cpu_rdata <= bus.mem_rdata;
      end
      if (ext_gnt && !bus.ext_we) begin
        ext_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus lock/starvation and reset sequences.
// Expected lock-sequence grants depend on whether ARB_STARVE_GUARD_EN is defined.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_arbiter_if #(.WIDTH(32)) bus ();

  dmem_arbiter #(.WIDTH(32), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dmem [256];
  assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_we) dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  typedef struct {
    string       name;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        ereq, ewe, elock;
    logic [31:0] eaddr, ewd;
    logic        cgnt, egnt, cstall, mwe;
    logic [31:0] maddr, mwd;
    logic        crv;
    logic [31:0] crd;
    logic        erv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n,
    input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
    input logic ereq, input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewd,
    input logic elock,
    input logic cgnt, input logic egnt, input logic cstall, input logic mwe,
    input logic [31:0] maddr, input logic [31:0] mwd,
    input logic crv, input logic [31:0] crd, input logic erv, input logic [31:0] erd);
    vec_t v;
    v.name = n; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd; v.elock = elock;
    v.cgnt = cgnt; v.egnt = egnt; v.cstall = cstall; v.mwe = mwe;
    v.maddr = maddr; v.mwd = mwd; v.crv = crv; v.crd = crd; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic ereq, input logic ewe,
                       input logic [31:0] eaddr, input logic [31:0] ewd, input logic elock);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.ext_req = ereq; bus.ext_we = ewe; bus.ext_addr = eaddr; bus.ext_wdata = ewd;
    bus.ext_lock = elock;
  endtask

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] A = 32'hA5A50024;
  localparam logic [31:0] W = 32'h12345678;
  localparam logic [31:0] C = 32'hCAFE0030;

  logic exp_c, exp_e;
  int   stalls;
  int   exp_stalls;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    dmem[8'h10] = D;
    dmem[8'h24] = A;
    dmem[8'h20] = 32'h0BAD0020;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //                 creq cwe caddr  cwd  ereq ewe eaddr  ewd elock cgnt egnt stl mwe maddr  mwd  crv crd ervs erd
    vecs.push_back(mk("cpu_rd10", 1, 0, 'h10, 0, 0, 0, 0,    0, 0,  1, 0, 0, 0, 'h10, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_a",   0, 0, 0,    0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0,    0, 1, D, 0, 0));
    vecs.push_back(mk("ext_rd24", 0, 0, 0,    0, 1, 0, 'h24, 0, 0,  0, 1, 0, 0, 'h24, 0, 0, D, 0, 0));
    vecs.push_back(mk("cont1",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  1, 0, 0, 0, 'h10, 0, 0, D, 1, A));
    vecs.push_back(mk("cont2",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  0, 1, 1, 0, 'h24, 0, 1, D, 0, A));
    vecs.push_back(mk("cont3",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  1, 0, 0, 0, 'h10, 0, 0, D, 1, A));
    vecs.push_back(mk("cont4",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  0, 1, 1, 0, 'h24, 0, 1, D, 0, A));
    vecs.push_back(mk("cont5",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  1, 0, 0, 0, 'h10, 0, 0, D, 1, A));
    vecs.push_back(mk("cont6",    1, 0, 'h10, 0, 1, 0, 'h24, 0, 0,  0, 1, 1, 0, 'h24, 0, 1, D, 0, A));
    vecs.push_back(mk("idle_b",   0, 0, 0,    0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0,    0, 0, D, 1, A));
    vecs.push_back(mk("ext_wr40", 0, 0, 0,    0, 1, 1, 'h40, W, 0,  0, 1, 0, 1, 'h40, W, 0, D, 0, A));
    vecs.push_back(mk("cpu_rd40", 1, 0, 'h40, 0, 0, 0, 0,    0, 0,  1, 0, 0, 0, 'h40, 0, 0, D, 0, A));
    vecs.push_back(mk("idle_c",   0, 0, 0,    0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0,    0, 1, W, 0, A));
    vecs.push_back(mk("wr_lose",  1, 1, 'h30, C, 1, 0, 'h24, 0, 0,  0, 1, 1, 0, 'h24, 0, 0, W, 0, A));
    vecs.push_back(mk("wr_win",   1, 1, 'h30, C, 0, 0, 0,    0, 0,  1, 0, 0, 1, 'h30, C, 0, W, 1, A));
    vecs.push_back(mk("idle_d",   0, 0, 0,    0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0,    0, 0, W, 0, A));
    vecs.push_back(mk("ext_rd30", 0, 0, 0,    0, 1, 0, 'h30, 0, 0,  0, 1, 0, 0, 'h30, 0, 0, W, 0, A));
    vecs.push_back(mk("idle_e",   0, 0, 0,    0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0,    0, 0, W, 1, C));

    repeat (2) @(negedge clk);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_ext_rvalid", bus.ext_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ext_rdata", bus.ext_rdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].ereq, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd, vecs[i].elock);
      #2;
      chk({vecs[i].name, ".cpu_gnt"},    bus.cpu_gnt,    vecs[i].cgnt);
      chk({vecs[i].name, ".ext_gnt"},    bus.ext_gnt,    vecs[i].egnt);
      chk({vecs[i].name, ".cpu_stall"},  bus.cpu_stall,  vecs[i].cstall);
      chk({vecs[i].name, ".mem_we"},     bus.mem_we,     vecs[i].mwe);
      chk({vecs[i].name, ".mem_addr"},   bus.mem_addr,   vecs[i].maddr);
      chk({vecs[i].name, ".mem_wdata"},  bus.mem_wdata,  vecs[i].mwd);
      chk({vecs[i].name, ".cpu_rvalid"}, bus.cpu_rvalid, vecs[i].crv);
      chk({vecs[i].name, ".cpu_rdata"},  bus.cpu_rdata,  vecs[i].crd);
      chk({vecs[i].name, ".ext_rvalid"}, bus.ext_rvalid, vecs[i].erv);
      chk({vecs[i].name, ".ext_rdata"},  bus.ext_rdata,  vecs[i].erd);
    end

    // Lone CPU access leaves rr pointing at EXT, so EXT wins and locks on the first contended cycle.
    @(negedge clk);
    drive(1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    #2;
    chk("lock_pre.cpu_gnt", bus.cpu_gnt, 1);
    stalls = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      drive(1, 0, 'h10, 0, (k <= 20), 0, 'h24, 0, (k <= 20));
      #2;
`ifdef ARB_STARVE_GUARD_EN
      exp_c = (k == 9) || (k == 18) || (k == 22);
`else
      exp_c = (k == 22);
`endif
      exp_e = (k <= 20) && !exp_c;
      chk($sformatf("lock%0d.cpu_gnt", k), bus.cpu_gnt, exp_c);
      chk($sformatf("lock%0d.ext_gnt", k), bus.ext_gnt, exp_e);
      chk($sformatf("lock%0d.cpu_stall", k), bus.cpu_stall, !exp_c);
      if (k <= 20 && bus.cpu_stall) stalls++;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_stalls = 18;
`else
    exp_stalls = 20;
`endif
    chk("lock_stall_count", stalls, exp_stalls);

    // Reset asserted in the middle of a CPU write grant.
    @(negedge clk);
    drive(1, 1, 'h20, 32'hFFFF0000, 0, 0, 0, 0, 0);
    #2;
    chk("rstwr.pre_mem_we", bus.mem_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstwr.mem_we", bus.mem_we, 0);
    chk("rstwr.cpu_gnt", bus.cpu_gnt, 0);
    chk("rstwr.ext_gnt", bus.ext_gnt, 0);
    chk("rstwr.cpu_stall", bus.cpu_stall, 0);
    chk("rstwr.mem_addr", bus.mem_addr, 0);
    chk("rstwr.mem_wdata", bus.mem_wdata, 0);
    chk("rstwr.cpu_rdata", bus.cpu_rdata, 0);
    chk("rstwr.ext_rdata", bus.ext_rdata, 0);
    chk("rstwr.cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rstwr.ext_rvalid", bus.ext_rvalid, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    chk("rstwr.dmem20", dmem[8'h20], 32'h0BAD0020);
    @(negedge clk);
    drive(1, 0, 'h10, 0, 1, 0, 'h24, 0, 0);
    #2;
    chk("rstwr.rr_cpu_gnt", bus.cpu_gnt, 1);
    chk("rstwr.rr_ext_gnt", bus.ext_gnt, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("final.cpu_rdata", bus.cpu_rdata, D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
